instr_sequencer: RTL

- Multi-cycle fetch/decode/execute controller for the 4-bit CPU. It sits directly upstream of the 4x4-bit register file.
- Fetches 8-bit instructions from a combinational instruction ROM and decodes them.
- Drives the register file's read/write addresses, computes ALU results from the register file's two read ports, and issues one-cycle write-back strobes.
- Owns the PC and the Z/C flags.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/alu4.sv | 47 ++++
 rtl/instr_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, sequencer state encoding and widths.
package cpu_pkg;

    localparam int DATA_W  = 4;
    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    function automatic logic writesReg(input logic [3:0] op);
        return (op > OP_NOP) && (op <= OP_INC);
    endfunction

    // MOV and LDI write a register but leave Z/C alone.
    function automatic logic setsFlags(input logic [3:0] op);
        return writesReg(op) && (op != OP_MOV) && (op != OP_LDI);
    endfunction

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU; carry is carry-out for ADD/INC, borrow for SUB, 0 otherwise.
module alu4
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        opcode,
    input  logic [1:0]        imm2,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = b;
            OP_LDI: result = {2'b00, imm2};
            OP_INC: begin
                wide   = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 4-bit CPU; owns PC, IR, result and Z/C flags.
// Define INSTR_SEQ_STEP_EN to add a 'step' input that holds the FSM in FETCH until sampled high.
//
// state       | meaning
// S_FETCH     | latch instr_in into IR, PC += 1 (waits for step when enabled)
// S_DECODE    | Rd/Rs drive the register file, read data settles
// S_EXECUTE   | ALU result and flags captured, jumps resolved
// S_WRITEBACK | RegWrite high, result written to Rd on the closing edge
// S_HALT      | terminal after HLT, left only by reset
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
`ifdef INSTR_SEQ_STEP_EN
    input  logic                step,
`endif
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic [1:0]          Rd,
    output logic [1:0]          Rs,
    input  logic [DATA_W-1:0]   ReadData1,
    input  logic [DATA_W-1:0]   ReadData2,
    output logic                RegWrite,
    output logic [DATA_W-1:0]   WriteData,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                halted
);

    localparam int TGT_W = (PC_WIDTH < 4) ? PC_WIDTH : 4;

    state_t              state, nextState;
    logic [PC_WIDTH-1:0] pc, jumpTarget;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   result, aluResult;
    logic [3:0]          opcode;
    logic                aluCarry, aluZero;
    logic                zFlag, cFlag, regWriteQ, haltedQ;
    logic                advance, loadIr, jumpTaken;

`ifdef INSTR_SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign opcode     = ir[7:4];
    assign jumpTarget = PC_WIDTH'(ir[TGT_W-1:0]);

    alu4 uAlu (
        .a      (ReadData1),
        .b      (ReadData2),
        .opcode (opcode),
        .imm2   (ir[1:0]),
        .result (aluResult),
        .carry  (aluCarry),
        .zero   (aluZero)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadIr    = 1'b0;
        jumpTaken = 1'b0;
        case (state)
            S_FETCH: begin
                if (advance) begin
                    loadIr    = 1'b1;
                    nextState = S_DECODE;
                end
            end
            S_DECODE: nextState = S_EXECUTE;
            S_EXECUTE: begin
                if (writesReg(opcode))    nextState = S_WRITEBACK;
                else if (opcode == OP_HLT) nextState = S_HALT;
                else                       nextState = S_FETCH;
                case (opcode)
                    OP_JMP:  jumpTaken = 1'b1;
                    OP_JZ:   jumpTaken = zFlag;
                    OP_JNZ:  jumpTaken = ~zFlag;
                    default: jumpTaken = 1'b0;
                endcase
            end
            S_WRITEBACK: nextState = S_FETCH;
            S_HALT:      nextState = S_HALT;
            default:     nextState = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            ir        <= '0;
            result    <= '0;
            zFlag     <= 1'b0;
            cFlag     <= 1'b0;
            regWriteQ <= 1'b0;
            haltedQ   <= 1'b0;
        end else begin
            regWriteQ <= (nextState == S_WRITEBACK);
            haltedQ   <= (nextState == S_HALT);
            if (loadIr) begin
                ir <= instr_in;
                pc <= pc + PC_WIDTH'(1);
            end
            if (state == S_EXECUTE) begin
                result <= aluResult;
                if (setsFlags(opcode)) begin
                    zFlag <= aluZero;
                    cFlag <= aluCarry;
                end
                if (jumpTaken) pc <= jumpTarget;
            end
        end
    end

    // Masking with reset drops a write that is pending when reset hits WRITEBACK.
    assign RegWrite   = regWriteQ & ~reset;
    assign pc_out     = pc;
    assign Rd         = ir[3:2];
    assign Rs         = ir[1:0];
    assign WriteData  = result;
    assign zero_flag  = zFlag;
    assign carry_flag = cFlag;
    assign halted     = haltedQ;

endmodule
